// File: rtl/nmr_pulse_gate_generator.sv
// NMR pulse gate generator: turns a trigger edge into a gated
// square-wave burst for the DAC formatter (genclk + enable).
module nmr_pulse_gate_generator #(
  parameter int CNTR_WIDTH  = 32,
  parameter int CYCLE_WIDTH = 16
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   trigger,
  input  logic                   abort,
  input  logic [CNTR_WIDTH-1:0]  cfg_half_period,
  input  logic [CYCLE_WIDTH-1:0] cfg_cycles,
  input  logic                   cfg_continuous,
  output logic                   genclk,
  output logic                   enable,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic                   trig_q;
  logic [CNTR_WIDTH-1:0]  hp_q, hp_d;
  logic [CYCLE_WIDTH-1:0] n_q, n_d;
  logic                   cont_q, cont_d;
  logic [CNTR_WIDTH-1:0]  half_q, half_d;
  logic [CYCLE_WIDTH-1:0] per_q, per_d;
  logic                   genclk_d;
  logic                   enable_d;
  logic                   busy_d;
  logic                   done_d;

  logic                   start_evt;
  logic                   start_ok;
  logic                   half_last;
  logic [CYCLE_WIDTH-1:0] per_inc;
  logic [CNTR_WIDTH-1:0]  hp_m1;

  assign start_evt = trigger & ~trig_q;
  assign start_ok  = start_evt
                   & (cfg_half_period != '0)
                   & ~abort
                   & (cfg_continuous | (cfg_cycles != '0));
  // hp_q is never zero in RUN, so hp_q-1 cannot wrap
  assign hp_m1     = hp_q - 1'b1;
  assign half_last = (half_q == hp_m1);
  assign per_inc   = per_q + 1'b1;

  // state, config latches, counters and registered outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q <= IDLE;
      trig_q  <= 1'b1;
      hp_q    <= '0;
      n_q     <= '0;
      cont_q  <= 1'b0;
      half_q  <= '0;
      per_q   <= '0;
      genclk  <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trigger;
      hp_q    <= hp_d;
      n_q     <= n_d;
      cont_q  <= cont_d;
      half_q  <= half_d;
      per_q   <= per_d;
      genclk  <= genclk_d;
      enable  <= enable_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // next-state, counter and output decode
  always_comb begin
    state_d  = state_q;
    hp_d     = hp_q;
    n_d      = n_q;
    cont_d   = cont_q;
    half_d   = half_q;
    per_d    = per_q;
    genclk_d = genclk;
    enable_d = enable;
    busy_d   = busy;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d  = RUN;
          hp_d     = cfg_half_period;
          n_d      = cfg_cycles;
          cont_d   = cfg_continuous;
          half_d   = '0;
          per_d    = '0;
          genclk_d = 1'b1;
          enable_d = 1'b1;
          busy_d   = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d  = IDLE;
          half_d   = '0;
          per_d    = '0;
          genclk_d = 1'b0;
          enable_d = 1'b0;
          busy_d   = 1'b0;
        end else if (!half_last) begin
          half_d = half_q + 1'b1;
        end else begin
          half_d = '0;
          if (genclk) begin
            genclk_d = 1'b0;
          end else if (!cont_q && per_inc == n_q) begin
            state_d  = IDLE;
            per_d    = '0;
            genclk_d = 1'b0;
            enable_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else begin
            per_d    = per_inc;
            genclk_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nmr_pulse_gate_generator.sv
// Testbench for nmr_pulse_gate_generator: directed vector table
// plus hand-written abort, continuous, full-scale and reset sequences.
module tb_nmr_pulse_gate_generator;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        trigger;
  logic        abort;
  logic [31:0] cfg_half_period;
  logic [15:0] cfg_cycles;
  logic        cfg_continuous;
  logic        genclk, enable, busy, done;

  int checks = 0;
  int failures = 0;

  nmr_pulse_gate_generator #(
    .CNTR_WIDTH(32),
    .CYCLE_WIDTH(16)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .trigger(trigger),
    .abort(abort),
    .cfg_half_period(cfg_half_period),
    .cfg_cycles(cfg_cycles),
    .cfg_continuous(cfg_continuous),
    .genclk(genclk),
    .enable(enable),
    .busy(busy),
    .done(done)
  );

  always #5 aclk = ~aclk;

  typedef struct {
    logic        trg;
    logic        abt;
    logic [31:0] hp;
    logic [15:0] n;
    logic        cont;
    logic [3:0]  exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic t, input logic a,
                     input logic [31:0] h, input logic [15:0] n,
                     input logic c, input logic [3:0] e);
    vec_t v;
    v.trg = t; v.abt = a; v.hp = h; v.n = n; v.cont = c; v.exp = e;
    vq.push_back(v);
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [3:0] exp);
    logic [3:0] got;
    got = {genclk, enable, busy, done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got gen/en/busy/done=%b want %b",
               name, got, exp);
    end
  endtask

  initial begin
    aresetn = 1'b0;
    trigger = 1'b0;
    abort = 1'b0;
    cfg_half_period = 32'd2;
    cfg_cycles = 16'd3;
    cfg_continuous = 1'b0;

    // hp=2 n=3 burst: 12 enable cycles then done
    add(0,0,2,3,0,4'b0000);
    add(1,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b1110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b0110);
    add(0,0,2,3,0,4'b0001);
    add(0,0,2,3,0,4'b0000);
    // hp=1 n=1, then back-to-back retrigger right after done
    add(1,0,1,1,0,4'b1110);
    add(0,0,1,1,0,4'b0110);
    add(0,0,1,1,0,4'b0001);
    add(1,0,1,1,0,4'b1110);
    add(0,0,1,1,0,4'b0110);
    add(0,0,1,1,0,4'b0001);
    add(0,0,1,1,0,4'b0000);
    // refused starts: hp=0, n=0 non-continuous, abort held
    add(1,0,0,3,0,4'b0000);
    add(0,0,0,3,0,4'b0000);
    add(1,0,2,0,0,4'b0000);
    add(0,0,2,0,0,4'b0000);
    add(1,1,2,3,0,4'b0000);
    add(0,0,2,3,0,4'b0000);
    // config change and retrigger during RUN are ignored
    add(1,0,2,1,0,4'b1110);
    add(0,0,5,9,1,4'b1110);
    add(1,0,5,9,1,4'b0110);
    add(0,0,5,9,1,4'b0110);
    add(0,0,5,9,1,4'b0001);
    add(0,0,5,9,1,4'b0000);
    // abort wins over a simultaneous normal end
    add(1,0,1,1,0,4'b1110);
    add(0,0,1,1,0,4'b0110);
    add(0,1,1,1,0,4'b0000);
    add(0,0,1,1,0,4'b0000);
    add(0,0,1,1,0,4'b0000);

    step();
    step();
    chk("reset_state", 4'b0000);
    aresetn = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      trigger = vq[i].trg;
      abort = vq[i].abt;
      cfg_half_period = vq[i].hp;
      cfg_cycles = vq[i].n;
      cfg_continuous = vq[i].cont;
      step();
      chk($sformatf("vec%0d", i), vq[i].exp);
    end

    // hp=3 n=10, abort on the 7th RUN cycle
    cfg_half_period = 32'd3;
    cfg_cycles = 16'd10;
    cfg_continuous = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("abort_run0", 4'b1110);
    for (int k = 1; k < 7; k++) begin
      step();
      chk($sformatf("abort_run%0d", k),
          {((k / 3) % 2 == 0) ? 1'b1 : 1'b0, 3'b110});
    end
    abort = 1'b1;
    step();
    chk("abort_stop", 4'b0000);
    abort = 1'b0;
    for (int k = 0; k < 30; k++) begin
      step();
      chk("abort_after", 4'b0000);
    end

    // continuous hp=4 for 1000 cycles, periodic retriggers
    cfg_half_period = 32'd4;
    cfg_cycles = 16'd0;
    cfg_continuous = 1'b1;
    trigger = 1'b1;
    step();
    chk("cont0", 4'b1110);
    for (int k = 1; k < 1000; k++) begin
      trigger = ((k % 37) == 5) ? 1'b1 : 1'b0;
      step();
      chk("cont_run",
          {((k / 4) % 2 == 0) ? 1'b1 : 1'b0, 3'b110});
    end
    trigger = 1'b0;
    abort = 1'b1;
    step();
    chk("cont_abort", 4'b0000);
    abort = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("cont_after", 4'b0000);
    end

    // full-scale half period: stays in high half without wrap
    cfg_half_period = 32'hFFFF_FFFF;
    cfg_cycles = 16'd1;
    cfg_continuous = 1'b0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("fullscale0", 4'b1110);
    for (int k = 0; k < 40; k++) begin
      step();
      chk("fullscale_hi", 4'b1110);
    end
    abort = 1'b1;
    step();
    chk("fullscale_abort", 4'b0000);
    abort = 1'b0;

    // reset mid-burst with trigger held high through release
    cfg_half_period = 32'd2;
    cfg_cycles = 16'd3;
    trigger = 1'b1;
    step();
    chk("rst_start", 4'b1110);
    step();
    step();
    aresetn = 1'b0;
    step();
    chk("rst_in0", 4'b0000);
    step();
    chk("rst_in1", 4'b0000);
    aresetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rst_held", 4'b0000);
    end
    trigger = 1'b0;
    step();
    chk("rst_low", 4'b0000);
    trigger = 1'b1;
    step();
    chk("rst_restart", 4'b1110);
    trigger = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nmr_pulse_gate_generator.md
Name: nmr_pulse_gate_generator

Overview:
- Sequencer stage directly upstream of the square-wave DAC formatter.
- Turns a trigger into a gated NMR excitation burst.
- Drives the formatter's `genclk` select with a programmable-period square toggle and its `enable` (tvalid) with the burst gate.
- Supports a fixed cycle count or continuous mode, with abort. Reports busy/done to the PS-side status logic.

Parameters:
- CNTR_WIDTH, 32, width of the half-period counter and cfg_half_period.
- CYCLE_WIDTH, 16, width of the period counter and cfg_cycles.

Ports:
- aclk  input  1  system clock; all logic on its rising edge.
- aresetn  input  1  synchronous active-low reset.
- trigger  input  1  start request; rising edge starts a burst.
- abort  input  1  level; terminates a running burst.
- cfg_half_period  input  CNTR_WIDTH  aclk cycles per half square period.
- cfg_cycles  input  CYCLE_WIDTH  full square periods per burst.
- cfg_continuous  input  1  1 = run until abort; cfg_cycles is ignored.
- genclk  output  1  square toggle to the DAC formatter, registered.
- enable  output  1  burst gate to the DAC formatter (tvalid), registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- States: IDLE, RUN. All outputs are registered.
- Reset (aresetn=0 at an edge):
  - State goes to IDLE.
  - genclk, enable, busy and done go to 0.
  - Counters clear.
  - The trigger history register trig_q is set to 1, so a trigger held high through reset release does NOT start a burst.
- Edge detect: start_evt = trigger & ~trig_q. trig_q <= trigger on every non-reset edge.
- IDLE -> RUN:
  - Condition: start_evt, cfg_half_period != 0, abort=0, and (cfg_continuous=1 or cfg_cycles != 0).
  - On that edge, latch hp=cfg_half_period, n=cfg_cycles and cont=cfg_continuous.
  - genclk<=1, enable<=1, busy<=1. half_cnt<=0, per_cnt<=0.
  - Latency: outputs high one cycle after trigger is first sampled high.
  - Config changes during RUN have no effect.
- Start refused: if start_evt occurs with any start condition false, stay in IDLE. No output change, no done.
- RUN, each edge:
  - If half_cnt != hp-1, then half_cnt++.
  - Else half_cnt<=0 and genclk toggles.
  - On a 0->1 toggle, per_cnt++.
  - One period = 2*hp cycles, high half first.
- Normal end (non-continuous):
  - Trigger point: the edge where genclk would toggle 0->1 and per_cnt+1 == n.
  - Go to IDLE. genclk<=0, enable<=0, busy<=0, done<=1 for exactly one cycle.
  - enable is therefore high for exactly 2*hp*n cycles.
- Continuous: never ends normally. per_cnt wraps modulo 2^CYCLE_WIDTH without effect.
- abort=1 in RUN:
  - Next state IDLE; genclk, enable and busy go to 0 on that edge. No done.
  - abort has priority over a simultaneous normal end, so no done is produced.
- trigger edges during RUN are ignored. They are not queued.
- A new burst may start on the edge right after done: back-to-back is allowed if a fresh rising edge is seen.
- hp=1 gives genclk toggling every cycle (period 2).
- Full-scale hp = 2^CNTR_WIDTH-1 must count without overflow.
- done is 0 in every cycle except the completion pulse.

Test Plan:
- hp=2, n=3, cont=0, trigger pulse -> genclk 1,1,0,0 repeated 3 times; enable high for 12 cycles; done high for 1 cycle on the next edge; busy low afterwards.
- hp=1, n=1 -> genclk 1,0; enable high 2 cycles; then done. Second trigger the cycle after done -> identical second burst.
- hp=3, n=10, abort asserted at cycle 7 of RUN -> enable and genclk 0 on the next edge; done never asserts; busy low.
- hp=0, or n=0 with cont=0 -> trigger produces no enable, no busy, no done.
- cont=1, hp=4 -> 50% duty with period 8 for 1000 cycles; retriggers are ignored; abort stops the burst cleanly with no done.
- Hold trigger high across an aresetn pulse mid-burst -> all outputs 0 during reset; no restart after release until trigger drops and rises again.
